// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU operation encodings and register-index width.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110
  } alu_op_e;

  localparam int REG_W = 5;

  // Only add/sub leave a meaningful overflow bit; other ops leave it stale.
  function automatic logic ovf_meaningful(input logic [3:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/exc_capture.sv
// Arithmetic-overflow trap capture: qualifies the raw ALU overflow bit, holds the
// pending trap and its EPC, and keeps a saturating count of traps taken.
module exc_capture
  import mips_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic [3:0]       alu_op,
  input  logic             alu_ovf,
  input  logic             trap_en,
  input  logic [SIZE-1:0]  pc,
  input  logic             exc_ack,
  output logic             ovf_hit,
  output logic             busy,
  output logic             exc_valid,
  output logic [SIZE-1:0]  exc_epc,
  output logic [CNT_W-1:0] exc_count
);

  logic             exc_valid_q, exc_valid_d;
  logic [SIZE-1:0]  exc_epc_q, exc_epc_d;
  logic [CNT_W-1:0] exc_count_q, exc_count_d;

  assign ovf_hit = trap_en && ovf_meaningful(alu_op) && alu_ovf;

  always_comb begin
    exc_valid_d = exc_valid_q;
    exc_epc_d   = exc_epc_q;
    exc_count_d = exc_count_q;
    if (capture && ovf_hit) begin
      exc_valid_d = 1'b1;
      exc_epc_d   = pc;
      if (exc_count_q != '1) exc_count_d = exc_count_q + CNT_W'(1);
    end else if (exc_ack) begin
      exc_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      exc_valid_q <= 1'b0;
      exc_epc_q   <= '0;
      exc_count_q <= '0;
    end else begin
      exc_valid_q <= exc_valid_d;
      exc_epc_q   <= exc_epc_d;
      exc_count_q <= exc_count_d;
    end
  end

  assign busy      = exc_valid_q;
  assign exc_valid = exc_valid_q;
  assign exc_epc   = exc_epc_q;
  assign exc_count = exc_count_q;

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register: captures ALU result, flags and control one cycle after EX,
// with stall/flush handshake and precise overflow trapping.
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int SIZE  = 32,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [SIZE-1:0]  alu_out,
  input  logic             alu_zero,
  input  logic             alu_ovf,
  input  logic             trap_en,
  input  logic [SIZE-1:0]  pc,
  input  logic [REG_W-1:0] rd,
  input  logic             reg_we,
  input  logic             mem_rd,
  input  logic             mem_wr,
  input  logic             branch,
  input  logic [SIZE-1:0]  store_data,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [SIZE-1:0]  out_result,
  output logic [SIZE-1:0]  out_store_data,
  output logic [REG_W-1:0] out_rd,
  output logic             out_reg_we,
  output logic             out_mem_rd,
  output logic             out_mem_wr,
  output logic             out_br_taken,
  output logic             exc_valid,
  output logic [SIZE-1:0]  exc_epc,
  input  logic             exc_ack,
  output logic [CNT_W-1:0] exc_count
);

  logic accept, take, ovf_hit, busy;

  logic             valid_q, valid_d;
  logic [SIZE-1:0]  result_q, result_d;
  logic [SIZE-1:0]  store_data_q, store_data_d;
  logic [REG_W-1:0] rd_q, rd_d;
  logic             reg_we_q, reg_we_d;
  logic             mem_rd_q, mem_rd_d;
  logic             mem_wr_q, mem_wr_d;
  logic             br_q, br_d;

  assign in_ready = !stall && !busy;
  assign accept   = in_valid && in_ready;
  // A flushed capture is killed before it can raise a trap.
  assign take     = accept && !flush;

  exc_capture #(.SIZE(SIZE), .CNT_W(CNT_W)) u_exc (
    .clk       (clk),
    .rst       (rst),
    .capture   (take),
    .alu_op    (alu_op),
    .alu_ovf   (alu_ovf),
    .trap_en   (trap_en),
    .pc        (pc),
    .exc_ack   (exc_ack),
    .ovf_hit   (ovf_hit),
    .busy      (busy),
    .exc_valid (exc_valid),
    .exc_epc   (exc_epc),
    .exc_count (exc_count)
  );

  always_comb begin
    valid_d      = valid_q;
    result_d     = result_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    reg_we_d     = reg_we_q;
    mem_rd_d     = mem_rd_q;
    mem_wr_d     = mem_wr_q;
    br_d         = br_q;
    if (flush || (!stall && !take)) begin
      valid_d  = 1'b0;
      reg_we_d = 1'b0;
      mem_rd_d = 1'b0;
      mem_wr_d = 1'b0;
      br_d     = 1'b0;
    end else if (take) begin
      result_d     = alu_out;
      store_data_d = store_data;
      rd_d         = rd;
      valid_d      = !ovf_hit;
      reg_we_d     = reg_we && !ovf_hit;
      mem_rd_d     = mem_rd && !ovf_hit;
      mem_wr_d     = mem_wr && !ovf_hit;
      br_d         = branch && alu_zero && !ovf_hit;
    end
  end

  // EX -> MEM boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= 1'b0;
      result_q     <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
      reg_we_q     <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      br_q         <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      result_q     <= result_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      reg_we_q     <= reg_we_d;
      mem_rd_q     <= mem_rd_d;
      mem_wr_q     <= mem_wr_d;
      br_q         <= br_d;
    end
  end

  assign out_valid      = valid_q;
  assign out_result     = result_q;
  assign out_store_data = store_data_q;
  assign out_rd         = rd_q;
  assign out_reg_we     = valid_q && reg_we_q;
  assign out_mem_rd     = valid_q && mem_rd_q;
  assign out_mem_wr     = valid_q && mem_wr_q;
  assign out_br_taken   = valid_q && br_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: table of single-instruction vectors through a scoreboard queue,
// plus hand-written stall, flush, counter-saturation and reset-during-trap sequences.
module tb_ex_mem_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        alu_zero, alu_ovf, trap_en;
  logic [31:0] pc;
  logic [4:0]  rd;
  logic        reg_we, mem_rd, mem_wr, branch;
  logic [31:0] store_data;
  logic        stall, flush;
  logic        out_valid;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd;
  logic        out_reg_we, out_mem_rd, out_mem_wr, out_br_taken;
  logic        exc_valid;
  logic [31:0] exc_epc;
  logic        exc_ack;
  logic [7:0]  exc_count;

  ex_mem_stage #(.SIZE(32), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .alu_out(alu_out), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
    .trap_en(trap_en), .pc(pc), .rd(rd), .reg_we(reg_we), .mem_rd(mem_rd),
    .mem_wr(mem_wr), .branch(branch), .store_data(store_data), .stall(stall),
    .flush(flush), .out_valid(out_valid), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd(out_rd), .out_reg_we(out_reg_we),
    .out_mem_rd(out_mem_rd), .out_mem_wr(out_mem_wr), .out_br_taken(out_br_taken),
    .exc_valid(exc_valid), .exc_epc(exc_epc), .exc_ack(exc_ack), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] res;
    logic        zero, ovf, trap;
    logic [31:0] pc;
    logic [4:0]  rd;
    logic        we, mrd, mwr, br;
    logic        fl;
    logic        e_valid, e_we, e_mrd, e_mwr, e_br, e_trap;
  } vec_t;

  typedef struct {
    logic        valid;
    logic [31:0] res, sd;
    logic [4:0]  rd;
    logic        we, mrd, mwr, br, exc;
    logic [31:0] epc;
    logic [7:0]  cnt;
  } exp_t;

  localparam int NV = 13;
  vec_t vecs[NV];
  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;
  logic [7:0]  exp_cnt = 8'h00;
  logic [31:0] exp_epc = 32'h0;

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] res,
                              input logic zero, input logic ovf, input logic trap,
                              input logic [31:0] p, input logic [4:0] r,
                              input logic [3:0] ctl, input logic fl,
                              input logic [4:0] ex, input logic tr);
    vec_t v;
    v.op = op; v.res = res; v.zero = zero; v.ovf = ovf; v.trap = trap;
    v.pc = p; v.rd = r;
    {v.we, v.mrd, v.mwr, v.br} = ctl;
    v.fl = fl;
    {v.e_valid, v.e_we, v.e_mrd, v.e_mwr, v.e_br} = ex;
    v.e_trap = tr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    in_valid = 0; alu_op = ALU_AND; alu_out = 0; alu_zero = 0; alu_ovf = 0;
    trap_en = 0; pc = 0; rd = 0; reg_we = 0; mem_rd = 0; mem_wr = 0; branch = 0;
    store_data = 0; stall = 0; flush = 0; exc_ack = 0;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1; alu_op = v.op; alu_out = v.res; alu_zero = v.zero; alu_ovf = v.ovf;
    trap_en = v.trap; pc = v.pc; rd = v.rd; reg_we = v.we; mem_rd = v.mrd;
    mem_wr = v.mwr; branch = v.br; store_data = v.res ^ 32'hA5A5_0000; flush = v.fl;
  endtask

  task automatic drive_trap(input logic [31:0] p);
    idle();
    in_valid = 1; alu_op = ALU_ADD; alu_ovf = 1; trap_en = 1; pc = p; reg_we = 1;
  endtask

  initial begin
    vec_t v;
    exp_t e;

    //                op       res           z  o  t  pc            rd  we/mrd/mwr/br fl  exp v/we/mrd/mwr/br trap
    vecs[0]  = mk(ALU_ADD, 32'h0000_0010, 0, 0, 0, 32'h0040_0000, 5, 4'b1000, 0, 5'b11000, 0);
    vecs[1]  = mk(ALU_ADD, 32'h8000_0000, 0, 1, 1, 32'h0040_0020, 6, 4'b1000, 0, 5'b00000, 1);
    vecs[2]  = mk(ALU_AND, 32'h0000_00F0, 0, 1, 1, 32'h0040_0024, 7, 4'b1000, 0, 5'b11000, 0);
    vecs[3]  = mk(ALU_ADD, 32'h7FFF_FFFF, 0, 1, 0, 32'h0040_0028, 8, 4'b1000, 0, 5'b11000, 0);
    vecs[4]  = mk(ALU_SUB, 32'h1234_5678, 0, 1, 0, 32'h0040_002C, 9, 4'b1000, 0, 5'b11000, 0);
    vecs[5]  = mk(ALU_SUB, 32'h8000_0001, 0, 1, 1, 32'h0040_0030, 0, 4'b0010, 0, 5'b00000, 1);
    vecs[6]  = mk(ALU_SUB, 32'h0000_0000, 1, 0, 0, 32'h0040_0034, 0, 4'b0001, 0, 5'b10001, 0);
    vecs[7]  = mk(ALU_SUB, 32'h0000_0004, 0, 0, 0, 32'h0040_0038, 0, 4'b0001, 0, 5'b10000, 0);
    vecs[8]  = mk(ALU_OR,  32'h0000_1000, 0, 1, 1, 32'h0040_003C, 10, 4'b1100, 0, 5'b11100, 0);
    vecs[9]  = mk(ALU_SUB, 32'h0000_0000, 1, 0, 0, 32'h0040_0040, 11, 4'b1001, 1, 5'b00000, 0);
    vecs[10] = mk(ALU_ADD, 32'hFFFF_FFFF, 0, 1, 1, 32'h0040_0044, 12, 4'b1000, 1, 5'b00000, 0);
    vecs[11] = mk(4'b0111, 32'h0000_0001, 0, 1, 1, 32'h0040_0048, 0, 4'b0010, 0, 5'b10010, 0);
    vecs[12] = mk(ALU_ADD, 32'hDEAD_BEEF, 0, 0, 0, 32'h0040_004C, 31, 4'b0010, 0, 5'b10010, 0);

    idle();
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_result", out_result, 0);
    chk("rst_out_rd", out_rd, 0);
    chk("rst_out_reg_we", out_reg_we, 0);
    chk("rst_exc_valid", exc_valid, 0);
    chk("rst_exc_epc", exc_epc, 0);
    chk("rst_exc_count", exc_count, 0);
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < NV; i++) begin
      v = vecs[i];
      @(negedge clk);
      idle();
      drive(v);
      #1;
      chk($sformatf("v%0d_in_ready", i), in_ready, 1);
      if (v.e_trap) begin
        exp_epc = v.pc;
        if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      end
      e.valid = v.e_valid; e.res = v.res; e.sd = v.res ^ 32'hA5A5_0000; e.rd = v.rd;
      e.we = v.e_we; e.mrd = v.e_mrd; e.mwr = v.e_mwr; e.br = v.e_br;
      e.exc = v.e_trap; e.epc = exp_epc; e.cnt = exp_cnt;
      sb.push_back(e);

      @(negedge clk);
      idle();
      e = sb.pop_front();
      chk($sformatf("v%0d_valid", i), out_valid, e.valid);
      chk($sformatf("v%0d_reg_we", i), out_reg_we, e.we);
      chk($sformatf("v%0d_mem_rd", i), out_mem_rd, e.mrd);
      chk($sformatf("v%0d_mem_wr", i), out_mem_wr, e.mwr);
      chk($sformatf("v%0d_br_taken", i), out_br_taken, e.br);
      chk($sformatf("v%0d_exc_valid", i), exc_valid, e.exc);
      chk($sformatf("v%0d_exc_count", i), exc_count, e.cnt);
      if (e.valid) begin
        chk($sformatf("v%0d_result", i), out_result, e.res);
        chk($sformatf("v%0d_rd", i), out_rd, e.rd);
        chk($sformatf("v%0d_store_data", i), out_store_data, e.sd);
      end
      if (e.exc) begin
        chk($sformatf("v%0d_exc_epc", i), exc_epc, e.epc);
        in_valid = 1;
        #1;
        chk($sformatf("v%0d_ready_pending", i), in_ready, 0);
        @(negedge clk);
        in_valid = 0;
        chk($sformatf("v%0d_no_capture_pending", i), out_valid, 0);
        chk($sformatf("v%0d_exc_held", i), exc_valid, 1);
        exc_ack = 1;
        @(negedge clk);
        exc_ack = 0;
        #1;
        chk($sformatf("v%0d_exc_cleared", i), exc_valid, 0);
        chk($sformatf("v%0d_epc_held", i), exc_epc, e.epc);
        chk($sformatf("v%0d_ready_after_ack", i), in_ready, 1);
      end
    end

    // stall: hold for three cycles, then capture the waiting instruction exactly once
    @(negedge clk);
    idle();
    in_valid = 1; alu_op = ALU_ADD; alu_out = 32'h55; rd = 3; reg_we = 1;
    @(negedge clk);
    chk("stall_pre_result", out_result, 32'h55);
    alu_out = 32'h77; rd = 4; stall = 1;
    #1;
    chk("stall_in_ready", in_ready, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_hold_valid", out_valid, 1);
      chk("stall_hold_result", out_result, 32'h55);
      chk("stall_hold_rd", out_rd, 3);
      chk("stall_hold_ready", in_ready, 0);
    end
    stall = 0;
    @(negedge clk);
    in_valid = 0;
    chk("stall_release_result", out_result, 32'h77);
    chk("stall_release_rd", out_rd, 4);
    chk("stall_release_valid", out_valid, 1);
    @(negedge clk);
    chk("stall_once_valid", out_valid, 0);

    // flush beats stall
    idle();
    in_valid = 1; alu_op = ALU_OR; alu_out = 32'h99; rd = 2; reg_we = 1;
    @(negedge clk);
    chk("fl_pre_we", out_reg_we, 1);
    in_valid = 0; stall = 1; flush = 1;
    @(negedge clk);
    idle();
    chk("fl_stall_valid", out_valid, 0);
    chk("fl_stall_we", out_reg_we, 0);

    // saturation of the trap counter
    for (int k = 0; k < 256; k++) begin
      @(negedge clk);
      drive_trap(32'(k * 4));
      if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
      @(negedge clk);
      idle();
      exc_ack = 1;
      @(negedge clk);
      exc_ack = 0;
    end
    chk("sat_exc_count", exc_count, exp_cnt);
    chk("sat_exc_count_ff", exc_count, 8'hFF);
    chk("sat_exc_epc", exc_epc, 32'd1020);

    // reset while a trap is pending
    @(negedge clk);
    drive_trap(32'h0000_1234);
    @(negedge clk);
    idle();
    chk("rtrap_pending", exc_valid, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    #1;
    chk("rtrap_exc_valid", exc_valid, 0);
    chk("rtrap_exc_epc", exc_epc, 0);
    chk("rtrap_exc_count", exc_count, 0);
    chk("rtrap_out_valid", out_valid, 0);
    chk("rtrap_out_result", out_result, 0);
    chk("rtrap_in_ready", in_ready, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
